// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares the single-port framebuffer RAM between the VGA scanout prefetcher
//   (fixed-length read bursts, priority) and the CPU single-access port. A
//   saturating wait counter lets a starved CPU override VGA priority at the
//   next arbitration (IDLE) cycle. Bursts are never preempted.
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   vga_req/vga_addr     : burst request and base address (held until vga_ack)
//   vga_ack              : 1-cycle pulse on beat 0 of a granted burst
//   vga_rdata/vga_rvalid : burst read data, one cycle after each beat
//   cpu_req/we/addr/wdata: single access request (held until cpu_ack)
//   cpu_ack              : 1-cycle pulse when the access is issued to RAM
//   cpu_rdata/cpu_rvalid : read data, one cycle after a read is issued
//   mem_*                : RAM macro port (1-cycle read latency)
//   stat_bursts, stat_cpu_stall : present only with FB_ARB_STATS_EN defined
// Configuration macro: FB_ARB_STATS_EN (adds saturating statistics counters).
module vga_fb_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int BURST_LEN    = 8,
  parameter int CPU_MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef FB_ARB_STATS_EN
  output logic [15:0]       stat_bursts,
  output logic [15:0]       stat_cpu_stall,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEAT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(CPU_MAX_WAIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VGA  = 2'd1;
  localparam logic [1:0] S_CPU  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              vga_ack_q, vga_ack_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              vga_rv_q, vga_rv_d;
  logic              cpu_rv_q, cpu_rv_d;
  logic              grant_vga, grant_cpu;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    vga_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_vga   = 1'b0;
    grant_cpu   = 1'b0;
    // A read issued last cycle returns its data this cycle; tag it by owner.
    vga_rv_d    = mem_en_q && !mem_we_q && (state_q == S_VGA);
    cpu_rv_d    = mem_en_q && !mem_we_q && (state_q == S_CPU);

    case (state_q)
      S_IDLE: begin
        if (cpu_req && (wait_q == WAIT_MAX)) grant_cpu = 1'b1;
        else if (vga_req)                    grant_vga = 1'b1;
        else if (cpu_req)                    grant_cpu = 1'b1;
        if (grant_vga) begin
          state_d    = S_VGA;
          beat_d     = '0;
          vga_ack_d  = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = vga_addr;  // latched: requester may change it after ack
        end else if (grant_cpu) begin
          state_d     = S_CPU;
          cpu_ack_d   = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end
      end
      S_VGA: begin
        if (beat_q == BEAT_LAST) begin
          state_d = S_IDLE;
        end else begin
          beat_d     = beat_q + 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;  // wraps modulo 2^ADDR_W
        end
      end
      S_CPU:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Starvation counter; the ack cycle itself (req still high) is not waiting.
    if (!cpu_req || grant_cpu || cpu_ack_q) wait_d = '0;
    else if (wait_q != WAIT_MAX)            wait_d = wait_q + 1'b1;
    else                                    wait_d = wait_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      vga_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vga_rv_q    <= 1'b0;
      cpu_rv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      vga_ack_q   <= vga_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vga_rv_q    <= vga_rv_d;
      cpu_rv_q    <= cpu_rv_d;
    end
  end

  assign vga_ack    = vga_ack_q;
  assign cpu_ack    = cpu_ack_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign vga_rvalid = vga_rv_q;
  assign cpu_rvalid = cpu_rv_q;
  // RAM output is already a register; gating with the registered valid keeps
  // the data buses at zero outside valid cycles and after reset.
  assign vga_rdata  = vga_rv_q ? mem_rdata : '0;
  assign cpu_rdata  = cpu_rv_q ? mem_rdata : '0;

`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_bursts_q, stat_bursts_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_bursts_d = stat_bursts_q;
    stat_stall_d  = stat_stall_q;
    if (grant_vga && stat_bursts_q != 16'hFFFF) stat_bursts_d = stat_bursts_q + 1'b1;
    // Stalled = requesting in any cycle other than the one carrying its ack.
    if (cpu_req && !cpu_ack_q && stat_stall_q != 16'hFFFF)
      stat_stall_d = stat_stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bursts_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_bursts_q <= stat_bursts_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_bursts    = stat_bursts_q;
  assign stat_cpu_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: requesters push expected RAM beats and
// read data on each ack; a negedge monitor pops and compares.
module tb_vga_fb_arbiter;
  localparam int BL = 8;
  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req, cpu_req, cpu_we;
  logic [15:0] vga_addr, cpu_addr, cpu_wdata;
  logic        vga_ack, vga_rvalid, cpu_ack, cpu_rvalid;
  logic [15:0] vga_rdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_bursts, stat_cpu_stall;
`endif

  vga_fb_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST_LEN(BL), .CPU_MAX_WAIT(MW)) dut (
    .clk(clk), .reset(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef FB_ARB_STATS_EN
    .stat_bursts(stat_bursts), .stat_cpu_stall(stat_cpu_stall),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM macro model and the bench's own view of its contents.
  logic [15:0] ram    [0:65535];
  logic [15:0] shadow [0:65535];
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        vga;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } beat_t;

  beat_t       mq[$];
  logic [15:0] vq[$];
  logic [15:0] cq[$];
  bit          vpend = 0, cpend = 0;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete(); vq.delete(); cq.delete();
      vpend = 0; cpend = 0;
    end else begin
      if (vga_rvalid || vpend) begin
        chk("vga_rvalid_timing", 32'(vga_rvalid), 32'(vpend));
        if (vga_rvalid) begin
          if (vq.size() == 0) fail_now("vga_rdata_unexpected");
          else chk("vga_rdata", 32'(vga_rdata), 32'(vq.pop_front()));
        end
      end
      if (cpu_rvalid || cpend) begin
        chk("cpu_rvalid_timing", 32'(cpu_rvalid), 32'(cpend));
        if (cpu_rvalid) begin
          if (cq.size() == 0) fail_now("cpu_rdata_unexpected");
          else chk("cpu_rdata", 32'(cpu_rdata), 32'(cq.pop_front()));
        end
      end
      vpend = 0; cpend = 0;
      if (vga_ack) begin
        chk("vga_ack_while_req", 32'(vga_req), 32'd1);
        for (int k = 0; k < BL; k++) begin
          logic [15:0] a;
          a = 16'(vga_addr + 16'(k));
          mq.push_back('{vga: 1'b1, we: 1'b0, addr: a, wdata: 16'h0});
          vq.push_back(shadow[a]);
        end
      end
      if (cpu_ack) begin
        chk("cpu_ack_while_req", 32'(cpu_req), 32'd1);
        mq.push_back('{vga: 1'b0, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata});
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
        else cq.push_back(shadow[cpu_addr]);
      end
      if (mem_en) begin
        if (mq.size() == 0) fail_now("mem_en_unexpected");
        else begin
          beat_t b;
          b = mq.pop_front();
          chk("mem_we", 32'(mem_we), 32'(b.we));
          chk("mem_addr", 32'(mem_addr), 32'(b.addr));
          if (b.we) chk("mem_wdata", 32'(mem_wdata), 32'(b.wdata));
          else if (b.vga) vpend = 1;
          else cpend = 1;
        end
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic vga_xfer(input logic [15:0] a, output int r_cyc, output int a_cyc);
    @(posedge clk); #1;
    vga_addr = a; vga_req = 1'b1; r_cyc = cyc; a_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vga_ack) begin a_cyc = cyc; break; end
    end
    if (a_cyc < 0) fail_now("vga_ack_timeout");
    @(posedge clk); #1 vga_req = 1'b0;
  endtask

  task automatic cpu_xfer(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output int r_cyc, output int a_cyc);
    @(posedge clk); #1;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; r_cyc = cyc; a_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ack) begin a_cyc = cyc; break; end
    end
    if (a_cyc < 0) fail_now("cpu_ack_timeout");
    @(posedge clk); #1 cpu_req = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_vga_ack"},    32'(vga_ack), 0);
    chk({name, "_vga_rvalid"}, 32'(vga_rvalid), 0);
    chk({name, "_vga_rdata"},  32'(vga_rdata), 0);
    chk({name, "_cpu_ack"},    32'(cpu_ack), 0);
    chk({name, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
    chk({name, "_cpu_rdata"},  32'(cpu_rdata), 0);
    chk({name, "_mem_en"},     32'(mem_en), 0);
    chk({name, "_mem_we"},     32'(mem_we), 0);
    chk({name, "_mem_addr"},   32'(mem_addr), 0);
    chk({name, "_mem_wdata"},  32'(mem_wdata), 0);
`ifdef FB_ARB_STATS_EN
    chk({name, "_stat_bursts"}, 32'(stat_bursts), 0);
    chk({name, "_stat_stall"},  32'(stat_cpu_stall), 0);
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int r1, a1, r2, a2, n_rv, n_en, got;

  initial begin
    rst = 1'b1;
    vga_req = 0; vga_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 16'(i * 40503 + 3);
      shadow[i] = 16'(i * 40503 + 3);
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    @(negedge clk) rst = 1'b0;

    // Reset in the middle of a burst, beat 3.
    @(posedge clk); #1 vga_addr = 16'h0500; vga_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vga_ack) begin got = 1; break; end
    end
    if (got == 0) fail_now("rst_test_ack_timeout");
    @(posedge clk); #1 vga_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midburst_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_rv = 0; n_en = 0;
    repeat (12) begin
      @(negedge clk);
      n_rv += int'(vga_rvalid);
      n_en += int'(mem_en);
    end
    chk("post_reset_rvalid_count", 32'(n_rv), 0);
    chk("post_reset_mem_en_count", 32'(n_en), 0);

    // Plain burst, then a burst that wraps the address space.
    vga_xfer(16'h0100, r1, a1);
    chk("vga_grant_latency", 32'(a1 - r1), 1);
    repeat (12) @(negedge clk);
    vga_xfer(16'hFFFE, r1, a1);
    chk("vga_wrap_grant_latency", 32'(a1 - r1), 1);
    repeat (12) @(negedge clk);

    // CPU write then read back.
    cpu_xfer(1'b1, 16'h0040, 16'h1234, r1, a1);
    chk("cpu_wr_latency", 32'(a1 - r1), 1);
    cpu_xfer(1'b0, 16'h0040, 16'h0000, r1, a1);
    chk("cpu_rd_latency", 32'(a1 - r1), 1);
    got = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_rvalid) begin got = 1; chk("cpu_readback_1234", 32'(cpu_rdata), 32'h1234); break; end
    end
    if (got == 0) fail_now("cpu_readback_missing");
    repeat (4) @(negedge clk);

    // Simultaneous requests with no CPU backlog: VGA first, CPU after burst+IDLE.
    pulse_reset();
    fork
      vga_xfer(16'h0200, r1, a1);
      cpu_xfer(1'b0, 16'h0041, 16'h0, r2, a2);
    join
    chk("tie_vga_latency", 32'(a1 - r1), 1);
    chk("tie_cpu_after_burst", 32'(a2 - a1), BL + 1);
    repeat (6) @(negedge clk);
`ifdef FB_ARB_STATS_EN
    chk("stat_bursts", 32'(stat_bursts), 1);
    chk("stat_cpu_stall", 32'(stat_cpu_stall), BL + 2);
`endif

    // VGA requesting continuously: CPU wins only once its wait saturates,
    // at the first IDLE after that, and VGA is granted again right after.
    @(posedge clk); #1 vga_addr = 16'h0300; vga_req = 1'b1;
    for (int it = 0; it < 3; it++) begin
      repeat ($urandom_range(0, BL)) @(posedge clk);
      cpu_xfer(1'b1, 16'(16'h0050 + it), 16'($urandom), r2, a2);
      checks++;
      if ((a2 - r2) < MW + 1 || (a2 - r2) > MW + BL + 1) begin
        errors++;
        $display("FAIL starve_bound: got latency %0d expected %0d..%0d", a2 - r2, MW + 1, MW + BL + 1);
      end
      got = -1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (vga_ack) begin got = cyc; break; end
      end
      chk("vga_resume_after_cpu", 32'(got - a2), 2);
    end
    @(posedge clk); #1 vga_req = 1'b0;
    repeat (BL + 4) @(negedge clk);

    // Random traffic from both requesters.
    fork
      begin
        int rr, aa;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 6)) @(posedge clk);
          if ($urandom_range(0, 1) == 1) vga_xfer(16'($urandom), rr, aa);
          else vga_xfer(16'(16'h0038 + $urandom_range(0, 15)), rr, aa);
        end
      end
      begin
        int rr, aa;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          cpu_xfer(1'($urandom), 16'(16'h0040 + $urandom_range(0, 15)), 16'($urandom), rr, aa);
        end
      end
    join
    repeat (BL + 6) @(negedge clk);
    chk("drain_mem_queue", 32'(mq.size()), 0);
    chk("drain_vga_queue", 32'(vq.size()), 0);
    chk("drain_cpu_queue", 32'(cq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
